// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan path: blank code, segment bit
// positions and the active-low hex glyph table.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n is the {g,f,e,d,c,b,a} pattern for nibble n, active-low.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low {g..a} segment pattern; the decimal point is handled
// by the caller.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous page select.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SW_W         = 2,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             Reset,
  input  logic [SW_W-1:0]                  sw,
  input  logic [(2**SW_W)*DIGITS*4-1:0]    page_data,
  input  logic [DIGITS-1:0]                dp_mask,
  output logic [DIGITS-1:0]                AN,
  output logic [7:0]                       dispcode,
  output logic                             frame_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic [SW_W-1:0]   r_sw_meta;
  logic [SW_W-1:0]   r_sw_sync;
  logic [SW_W-1:0]   r_page;

  logic              w_slot_end;
  logic              w_wrap;
  logic              w_blank_phase;
  logic              w_lz_blank;
  logic [3:0]        w_nib;
  logic [6:0]        w_seg;
  logic [DIGITS-1:0] w_an;
  logic [7:0]        w_dispcode;

  assign w_slot_end    = (r_presc == PRESC_MAX);
  assign w_wrap        = w_slot_end && (r_idx == IDX_MAX);
  assign w_blank_phase = (r_presc < BLANK_END);
  assign w_nib         = page_data[(int'(r_page) * DIGITS + int'(r_idx)) * 4 +: 4];

  seg7_hex_decode u_hex_decode (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

`ifdef SEG7_LZB_EN
  // Blank when this digit and every higher one on the page is zero.
  always_comb begin
    w_lz_blank = (r_idx != '0) && !dp_mask[r_idx];
    for (int d = 0; d < DIGITS; d++) begin
      if ((d >= int'(r_idx)) &&
          (page_data[(int'(r_page) * DIGITS + d) * 4 +: 4] != 4'h0))
        w_lz_blank = 1'b0;
    end
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_an       = '1;
    w_dispcode = SEG_BLANK;
    if (!w_blank_phase && !w_lz_blank) begin
      w_an[r_idx] = 1'b0;
      w_dispcode  = {~dp_mask[r_idx], w_seg};
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_page     <= '0;
      AN         <= '1;
      dispcode   <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_presc   <= w_slot_end ? '0 : r_presc + 1'b1;
      if (w_slot_end)
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      // Page only switches at the frame boundary so a frame never mixes pages.
      if (w_wrap)
        r_page <= r_sw_sync;
      AN         <= w_an;
      dispcode   <= w_dispcode;
      frame_tick <= w_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (CLK_DIV=4, BLANK_CYCLES=1, 4 digits, 4 pages).
module tb_seg7_scan_ctrl;

  localparam int DIGITS  = 4;
  localparam int SW_W    = 2;
  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;
  localparam int FRAME   = CLK_DIV * DIGITS;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  sw = '0;
  logic [63:0] page_data = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  AN;
  logic [7:0]  dispcode;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  int m     = 0;
  int ticks = 0;
  logic [1:0]  sw_q[$];
  logic [63:0] pd_s;
  logic [3:0]  dp_s;

  seg7_scan_ctrl #(
    .DIGITS       (DIGITS),
    .SW_W         (SW_W),
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .sw         (sw),
    .page_data  (page_data),
    .dp_mask    (dp_mask),
    .AN         (AN),
    .dispcode   (dispcode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s m=%0d observed=%h expected=%h", tag, m, got, exp);
    end
  endtask

  // One clock: record what the DUT sampled, then compare against the model.
  task automatic step();
    int s, p, idx, f, pg;
    logic [3:0] nib, ea;
    logic [7:0] ed, h;
    logic et, lz;
    @(posedge clk);
    if (Reset) begin
      m++;
      sw_q.push_back(sw);
      pd_s = page_data;
      dp_s = dp_mask;
    end
    #1;
    if (!Reset) begin
      check("rst_an", {4'h0, AN}, 8'h0F);
      check("rst_disp", dispcode, 8'hFF);
      check("rst_tick", {7'h0, frame_tick}, 8'h00);
    end else begin
      s   = m - 1;
      p   = s % CLK_DIV;
      idx = (s / CLK_DIV) % DIGITS;
      f   = s / FRAME;
      pg  = (f == 0) ? 0 : int'(sw_q[FRAME * f - 3]);
      et  = (s % FRAME) == FRAME - 1;
      nib = 4'(pd_s >> ((pg * DIGITS + idx) * 4));
      lz  = 1'b0;
`ifdef SEG7_LZB_EN
      lz = (idx != 0) && !dp_s[idx];
      for (int d = idx; d < DIGITS; d++)
        if (4'(pd_s >> ((pg * DIGITS + d) * 4)) != 4'h0) lz = 1'b0;
`endif
      ea = 4'hF;
      ed = 8'hFF;
      if (p >= BLANK && !lz) begin
        ea[idx] = 1'b0;
        h  = hex7(nib);
        ed = {~dp_s[idx], h[6:0]};
      end
      check("an", {4'h0, AN}, {4'h0, ea});
      check("disp", dispcode, ed);
      check("tick", {7'h0, frame_tick}, {7'h0, et});
      if (frame_tick) ticks++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    Reset = 1'b1;
    m = 0;
    sw_q.delete();
  endtask

  initial begin
    // Reset held, then released; first lit slot is digit 0.
    run(3);
    release_reset();
    page_data[15:0] = 16'h1234;
    run(2);
    check("first_lit_an", {4'h0, AN}, 8'h0E);

    // Page 0 = 1234 over two frames; count ticks.
    ticks = 0;
    run(30);
    check("tick_count", 8'(ticks), 8'd2);

    // Toggle sw mid-frame with page 1 = ABCD.
    page_data[31:16] = 16'hABCD;
    run(6);
    sw = 2'd1;
    run(40);

    // Decimal point on digit 2, page 0 = 8888.
    sw = 2'd0;
    page_data[15:0] = 16'h8888;
    dp_mask = 4'b0100;
    run(48);

    // Random data, dp and occasional page changes.
    for (int i = 0; i < 320; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      for (int k = 0; k < 16; k++)
        if ($urandom_range(1, 0) == 0) r[k*4 +: 4] = 4'h0;
      page_data = r;
      dp_mask   = 4'($urandom_range(15, 0));
      if ($urandom_range(7, 0) == 0) sw = 2'($urandom_range(3, 0));
      step();
    end

    // Async reset at digit 2, prescaler 3.
    dp_mask = '0;
    for (int i = 0; i < 2 * FRAME && !((m % CLK_DIV == 3) && ((m / CLK_DIV) % DIGITS == 2)); i++)
      step();
    check("pre_rst_state", 8'((m / CLK_DIV) % DIGITS), 8'd2);
    #2;
    Reset = 1'b0;
    #1;
    check("async_an", {4'h0, AN}, 8'h0F);
    check("async_disp", dispcode, 8'hFF);
    run(2);
    sw = 2'd0;
    page_data = '0;
    page_data[15:0] = 16'h0050;
    release_reset();
    run(2);
    check("restart_an", {4'h0, AN}, 8'h0E);
    run(30);

    // Zero-heavy pages for leading-zero handling.
    page_data[15:0] = 16'h0000;
    run(32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
